// File: rtl/mac_sequencer.sv
// Dot-product sequencer: streams operand vectors from two memories into a MAC,
// masks the tail beat, then holds the MAC result until it is consumed.
module mac_sequencer #(
    parameter int unsigned FRAC_WIDTH  = 24,
    parameter int unsigned EXP_WIDTH   = 8,
    parameter int unsigned VECTOR_SIZE = 8,
    parameter int unsigned LEN_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH  = 12,
    localparam int unsigned DATA_WIDTH = FRAC_WIDTH + EXP_WIDTH
) (
    input  logic                              clkIn,
    input  logic                              rstIn,
    input  logic                              cmdValidIn,
    output logic                              cmdReadyOut,
    input  logic [LEN_WIDTH-1:0]              cmdLenIn,
    input  logic [ADDR_WIDTH-1:0]             cmdBaseAIn,
    input  logic [ADDR_WIDTH-1:0]             cmdBaseBIn,
    output logic                              rdEnOut,
    output logic [ADDR_WIDTH-1:0]             rdAddrAOut,
    output logic [ADDR_WIDTH-1:0]             rdAddrBOut,
    input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] rdDataAIn,
    input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] rdDataBIn,
    output logic [DATA_WIDTH*VECTOR_SIZE-1:0] macDataAOut,
    output logic [DATA_WIDTH*VECTOR_SIZE-1:0] macDataBOut,
    output logic [VECTOR_SIZE-1:0]            macValidOut,
    output logic                              macLastOut,
    input  logic [DATA_WIDTH-1:0]             macDataIn,
    input  logic                              macValidIn,
    output logic [DATA_WIDTH-1:0]             resultDataOut,
    output logic                              resultValidOut,
    input  logic                              resultReadyIn,
    output logic                              busyOut
);

    localparam int unsigned LogVs = $clog2(VECTOR_SIZE);
    localparam int unsigned RemW  = (LogVs > 0) ? LogVs : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0]   addr_b_q, addr_b_d;
    logic [LEN_WIDTH-1:0]    beats_q, beats_d;
    logic [RemW-1:0]         rem_q, rem_d;
    logic [VECTOR_SIZE-1:0]  mac_valid_q, mac_valid_d;
    logic                    mac_last_q, mac_last_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic [VECTOR_SIZE-1:0]  tail_mask;
    logic                    last_beat;

    assign last_beat = (beats_q == LEN_WIDTH'(1));

    // A zero remainder means the final beat is full.
    always_comb begin
        tail_mask = '0;
        for (int i = 0; i < int'(VECTOR_SIZE); i++) begin
            tail_mask[i] = (rem_q == '0) || (RemW'(i) < rem_q);
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        beats_d     = beats_q;
        rem_d       = rem_q;
        mac_valid_d = '0;
        mac_last_d  = 1'b0;
        result_d    = result_q;
        unique case (state_q)
            StIdle: begin
                if (cmdValidIn) begin
                    if (cmdLenIn == '0) begin
                        result_d = '0;
                        state_d  = StHold;
                    end else begin
                        addr_a_d = cmdBaseAIn;
                        addr_b_d = cmdBaseBIn;
                        beats_d  = LEN_WIDTH'(({1'b0, cmdLenIn}
                                   + (LEN_WIDTH + 1)'(VECTOR_SIZE - 1)) >> LogVs);
                        rem_d    = RemW'(cmdLenIn % LEN_WIDTH'(VECTOR_SIZE));
                        state_d  = StIssue;
                    end
                end
            end
            StIssue: begin
                mac_valid_d = last_beat ? tail_mask : '1;
                mac_last_d  = last_beat;
                addr_a_d    = addr_a_q + ADDR_WIDTH'(1);
                addr_b_d    = addr_b_q + ADDR_WIDTH'(1);
                beats_d     = beats_q - LEN_WIDTH'(1);
                if (last_beat) state_d = StWait;
            end
            StWait: begin
                if (macValidIn) begin
                    result_d = macDataIn;
                    state_d  = StHold;
                end
            end
            StHold: begin
                if (resultReadyIn) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            state_q     <= StIdle;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            beats_q     <= '0;
            rem_q       <= '0;
            mac_valid_q <= '0;
            mac_last_q  <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            beats_q     <= beats_d;
            rem_q       <= rem_d;
            mac_valid_q <= mac_valid_d;
            mac_last_q  <= mac_last_d;
            result_q    <= result_d;
        end
    end

    assign cmdReadyOut    = (state_q == StIdle);
    assign rdEnOut        = (state_q == StIssue);
    assign rdAddrAOut     = addr_a_q;
    assign rdAddrBOut     = addr_b_q;
    assign macDataAOut    = rdDataAIn;
    assign macDataBOut    = rdDataBIn;
    assign macValidOut    = mac_valid_q;
    assign macLastOut     = mac_last_q;
    assign resultDataOut  = result_q;
    assign resultValidOut = (state_q == StHold);
    assign busyOut        = (state_q != StIdle);

endmodule
